// File: rtl/openram_wb_arbiter.sv
// Two-port Wishbone classic arbiter sharing the OpenRAM RW port 0.
// Each access runs IDLE -> CMD -> (WAIT) -> ACK; ownership alternates round-robin.
module openram_wb_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_a_cyc_i,
    input  logic                  wbs_a_stb_i,
    input  logic                  wbs_a_we_i,
    input  logic [3:0]            wbs_a_sel_i,
    input  logic [31:0]           wbs_a_adr_i,
    input  logic [31:0]           wbs_a_dat_i,
    output logic                  wbs_a_ack_o,
    output logic [31:0]           wbs_a_dat_o,
    input  logic                  wbs_b_cyc_i,
    input  logic                  wbs_b_stb_i,
    input  logic                  wbs_b_we_i,
    input  logic [3:0]            wbs_b_sel_i,
    input  logic [31:0]           wbs_b_adr_i,
    input  logic [31:0]           wbs_b_dat_i,
    output logic                  wbs_b_ack_o,
    output logic [31:0]           wbs_b_dat_o,
    output logic                  openram_clk0,
    output logic                  openram_csb0,
    output logic                  openram_web0,
    output logic [3:0]            openram_wmask0,
    output logic [ADDR_WIDTH-1:0] openram_addr0,
    output logic [31:0]           openram_dout0,
    input  logic [31:0]           openram_din0,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        last_b;
    logic        req_a, req_b, pick_b, any_req;
    logic        sel_we;
    logic [3:0]  sel_sel;
    logic [31:0] sel_adr, sel_dat;
    logic        unused_adr_bits;

    assign openram_clk0 = wb_clk_i;

    assign req_a   = wbs_a_cyc_i & wbs_a_stb_i;
    assign req_b   = wbs_b_cyc_i & wbs_b_stb_i;
    assign any_req = req_a | req_b;
    // On contention the port that did not own the last access wins.
    assign pick_b  = req_b & (~req_a | ~last_b);

    assign sel_we  = pick_b ? wbs_b_we_i  : wbs_a_we_i;
    assign sel_sel = pick_b ? wbs_b_sel_i : wbs_a_sel_i;
    assign sel_adr = pick_b ? wbs_b_adr_i : wbs_a_adr_i;
    assign sel_dat = pick_b ? wbs_b_dat_i : wbs_a_dat_i;

    // Byte-offset and out-of-window address bits are decoded upstream.
    assign unused_adr_bits = ^{wbs_a_adr_i[31:ADDR_WIDTH+2], wbs_a_adr_i[1:0],
                               wbs_b_adr_i[31:ADDR_WIDTH+2], wbs_b_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this process gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (any_req) state_next = S_CMD;
            S_CMD:  state_next = openram_web0 ? S_WAIT : S_ACK;
            S_WAIT: if (wait_cnt == 4'd1) state_next = S_ACK;
            S_ACK:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            openram_csb0   <= 1'b1;
            openram_web0   <= 1'b1;
            openram_wmask0 <= 4'b0;
            openram_addr0  <= '0;
            openram_dout0  <= 32'b0;
            wbs_a_ack_o    <= 1'b0;
            wbs_b_ack_o    <= 1'b0;
            wbs_a_dat_o    <= 32'b0;
            wbs_b_dat_o    <= 32'b0;
            grant_o        <= 2'b00;
            last_b         <= 1'b1;
            wait_cnt       <= 4'd0;
        end else begin
            wbs_a_ack_o <= 1'b0;
            wbs_b_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        openram_csb0   <= 1'b0;
                        openram_web0   <= ~sel_we;
                        openram_wmask0 <= sel_we ? sel_sel : 4'b0;
                        openram_addr0  <= sel_adr[ADDR_WIDTH+1:2];
                        openram_dout0  <= sel_dat;
                        grant_o        <= pick_b ? 2'b10 : 2'b01;
                        last_b         <= pick_b;
                    end
                end
                S_CMD: begin
                    openram_csb0 <= 1'b1;
                    openram_web0 <= 1'b1;
                    if (openram_web0) begin
                        wait_cnt <= 4'(READ_LATENCY);
                    end else begin
                        wbs_a_ack_o <= grant_o[0] & wbs_a_cyc_i;
                        wbs_b_ack_o <= grant_o[1] & wbs_b_cyc_i;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        if (grant_o[1]) wbs_b_dat_o <= openram_din0;
                        else            wbs_a_dat_o <= openram_din0;
                        wbs_a_ack_o <= grant_o[0] & wbs_a_cyc_i;
                        wbs_b_ack_o <= grant_o[1] & wbs_b_cyc_i;
                    end
                end
                S_ACK: grant_o <= 2'b00;
                default: grant_o <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_openram_wb_arbiter.sv
// Directed self-checking bench for openram_wb_arbiter (default latency plus a READ_LATENCY=3 copy).
module tb_openram_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [3:0]  a_sel, b_sel;
    logic [31:0] a_adr, a_dat, b_adr, b_dat, din;

    logic        a_ack, b_ack, ram_clk, csb, web;
    logic [31:0] a_rd, b_rd, dout;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [1:0]  grant;

    logic        a_ack3, b_ack3, ram_clk3, csb3, web3;
    logic [31:0] a_rd3, b_rd3, dout3;
    logic [3:0]  wmask3;
    logic [7:0]  addr3;
    logic [1:0]  grant3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    openram_wb_arbiter #(.ADDR_WIDTH(8), .READ_LATENCY(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_a_cyc_i(a_cyc), .wbs_a_stb_i(a_stb), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
        .wbs_a_adr_i(a_adr), .wbs_a_dat_i(a_dat), .wbs_a_ack_o(a_ack), .wbs_a_dat_o(a_rd),
        .wbs_b_cyc_i(b_cyc), .wbs_b_stb_i(b_stb), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
        .wbs_b_adr_i(b_adr), .wbs_b_dat_i(b_dat), .wbs_b_ack_o(b_ack), .wbs_b_dat_o(b_rd),
        .openram_clk0(ram_clk), .openram_csb0(csb), .openram_web0(web),
        .openram_wmask0(wmask), .openram_addr0(addr), .openram_dout0(dout),
        .openram_din0(din), .grant_o(grant)
    );

    openram_wb_arbiter #(.ADDR_WIDTH(8), .READ_LATENCY(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_a_cyc_i(a_cyc), .wbs_a_stb_i(a_stb), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
        .wbs_a_adr_i(a_adr), .wbs_a_dat_i(a_dat), .wbs_a_ack_o(a_ack3), .wbs_a_dat_o(a_rd3),
        .wbs_b_cyc_i(b_cyc), .wbs_b_stb_i(b_stb), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
        .wbs_b_adr_i(b_adr), .wbs_b_dat_i(b_dat), .wbs_b_ack_o(b_ack3), .wbs_b_dat_o(b_rd3),
        .openram_clk0(ram_clk3), .openram_csb0(csb3), .openram_web0(web3),
        .openram_wmask0(wmask3), .openram_addr0(addr3), .openram_dout0(dout3),
        .openram_din0(din), .grant_o(grant3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drop_all();
        a_cyc = 0; a_stb = 0; a_we = 0;
        b_cyc = 0; b_stb = 0; b_we = 0;
    endtask

    initial begin : stim
        logic [1:0] grants [$];
        logic [1:0] prev_grant;
        logic       prev_csb;
        int         adj_low, a_acks, b_acks, bad_onehot;

        rst = 1;
        drop_all();
        a_sel = 4'hF; b_sel = 4'hF;
        a_adr = 0; a_dat = 0; b_adr = 0; b_dat = 0; din = 0;
        #1;
        check("rst_csb", csb, 1);
        check("rst_web", web, 1);
        check("rst_wmask", wmask, 0);
        check("rst_addr", addr, 0);
        check("rst_dout", dout, 0);
        check("rst_grant", grant, 0);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_dat", a_rd | b_rd, 0);
        step(); step();
        rst = 0;
        step();

        // Port A read, default latency
        a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 32'h0000_0010; din = 32'hDEAD_BEEF;
        step();
        check("rdA_cmd", {csb, web, wmask, addr}, {1'b0, 1'b1, 4'h0, 8'h04});
        check("rdA_grant", grant, 2'b01);
        step();
        check("rdA_nack_t2", a_ack, 0);
        step();
        check("rdA_ack", a_ack, 1);
        check("rdA_dat", a_rd, 32'hDEAD_BEEF);
        check("rdA_backB", b_ack, 0);
        drop_all();
        step();
        check("rdA_ack_gone", {a_ack, grant}, 0);

        // Port B write
        b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 32'h0000_03FC; b_dat = 32'h1234_5678; b_sel = 4'b0101;
        step();
        check("wrB_ctl", {csb, web, wmask, addr}, {1'b0, 1'b0, 4'b0101, 8'hFF});
        check("wrB_dout", dout, 32'h1234_5678);
        check("wrB_grant", grant, 2'b10);
        step();
        check("wrB_ack", {a_ack, b_ack}, 2'b01);
        check("wrB_csb_hi", csb, 1);
        drop_all();
        step();
        check("wrB_ack_once", b_ack, 0);

        // Both ports read continuously: six grants alternating A, B
        a_cyc = 1; a_stb = 1; a_we = 0; b_cyc = 1; b_stb = 1; b_we = 0;
        prev_grant = 0; prev_csb = 1; adj_low = 0; a_acks = 0; b_acks = 0; bad_onehot = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (prev_grant == 2'b00 && grant != 2'b00) grants.push_back(grant);
            if (grant == 2'b11) bad_onehot++;
            if (!prev_csb && !csb) adj_low++;
            if (a_ack) a_acks++;
            if (b_ack) b_acks++;
            prev_grant = grant;
            prev_csb = csb;
            if (c == 23) drop_all();
        end
        check("rr_count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        check("rr_onehot", bad_onehot, 0);
        check("rr_csb_adjacent", adj_low, 0);
        check("rr_acks", {a_acks[7:0], b_acks[7:0]}, {8'd3, 8'd3});

        // Port A read abandoned during WAIT, B queued behind it
        step();
        a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 32'h0000_0008; din = 32'hCAFE_F00D;
        step();
        check("abn_cmd", {csb, grant}, {1'b0, 2'b01});
        b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 32'h0000_0020; b_dat = 32'h0BAD_CAFE; b_sel = 4'hF;
        step();
        check("abn_wait_grant", grant, 2'b01);
        a_cyc = 0; a_stb = 0;
        step();
        check("abn_no_ack", {a_ack, b_ack}, 0);
        check("abn_dat_done", a_rd, 32'hCAFE_F00D);
        step();
        check("abn_idle", grant, 0);
        step();
        check("abn_b_grant", {csb, web, grant, addr}, {1'b0, 1'b0, 2'b10, 8'h08});
        step();
        check("abn_b_ack", {a_ack, b_ack}, 2'b01);
        drop_all();
        step();

        // Reset during CMD of a write, then simultaneous request
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 32'h0000_0004; a_dat = 32'h5555_AAAA;
        step();
        check("rstm_cmd", {csb, web}, 2'b00);
        #2 rst = 1;
        #1;
        check("rstm_async", {csb, web, grant, a_ack}, {1'b1, 1'b1, 2'b00, 1'b0});
        step();
        check("rstm_held_noack", {a_ack, csb}, 2'b01);
        rst = 0;
        b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 0;
        step();
        check("rstm_a_first", grant, 2'b01);
        step();
        check("rstm_a_ack", {a_ack, b_ack}, 2'b10);
        drop_all();
        step(); step(); step();

        // READ_LATENCY = 3 copy: ack at t+5, data from din in cycle t+4
        a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 32'h0000_0020; din = 32'h1111_1111;
        step();
        check("rl3_cmd", {csb3, addr3}, {1'b0, 8'h08});
        din = 32'h2222_2222;
        step();
        din = 32'h3333_3333;
        step();
        din = 32'h4444_4444;
        step();
        check("rl3_no_early_ack", a_ack3, 0);
        step();
        check("rl3_ack", a_ack3, 1);
        check("rl3_dat", a_rd3, 32'h4444_4444);
        din = 32'h5555_5555;
        drop_all();
        step();
        check("rl3_dat_held", {a_ack3, a_rd3}, {1'b0, 32'h4444_4444});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
